// File: rtl/pdp1_tp_chain.sv
// PDP-1 core-cycle timing-pulse chain.
// It emits one-hot tp pulses STEP clocks apart and free-runs until stopped. It can park after tp[HOLD_TP] until ioc arrives.
module pdp1_tp_chain #(
  parameter int STEP    = 25,
  parameter int NTP     = 10,
  parameter int HOLD_TP = 7
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic           stop,
  input  logic           ihold,
  input  logic           ioc,
  output logic [NTP-1:0] tp,
  output logic           run,
  output logic           paused,
  output logic           cyc_end
);

  localparam int CW = $clog2(STEP + 1);
  localparam int IW = $clog2(NTP);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP);
  localparam logic [IW-1:0] IDX_LAST = IW'(NTP - 1);
  localparam logic [IW-1:0] IDX_HOLD = IW'(HOLD_TP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STEP,
    S_PAUSE
  } state_e;

  typedef struct packed {
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
  } pos_t;

  // On resume, the ioc cycle counts as the second clock of the held step.
  // The next pulse then lands STEP-1 clocks after ioc, including when STEP == 2.
  localparam pos_t HOLD_POS = '{cnt: CW'(2), idx: IDX_HOLD};

  state_e state_q, state_d;
  pos_t   pos_q, pos_d;
  logic   fire, at_hold, at_last;

  // One clock of progress along the chain: bump cnt, or wrap it and move to the next pulse.
  function automatic pos_t advance(input pos_t p);
    pos_t n;
    n = p;
    if (p.cnt == CNT_LAST) begin
      n.cnt = CNT_ONE;
      n.idx = (p.idx == IDX_LAST) ? '0 : p.idx + IW'(1);
    end else begin
      n.cnt = p.cnt + CW'(1);
    end
    return n;
  endfunction

  assign fire    = (state_q == S_STEP) && (pos_q.cnt == CNT_ONE);
  assign at_hold = fire && (pos_q.idx == IDX_HOLD);
  assign at_last = fire && (pos_q.idx == IDX_LAST);

  // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STEP;
          pos_d   = '{cnt: CNT_ONE, idx: '0};
        end
      end
      S_STEP: begin
        if (at_last && stop) begin
          state_d = S_IDLE;
          pos_d   = '0;
        end else if (at_hold && ihold) begin
          state_d = S_PAUSE;
        end else begin
          pos_d = advance(pos_q);
        end
      end
      S_PAUSE: begin
        if (ioc) begin
          state_d = S_STEP;
          pos_d   = advance(HOLD_POS);
        end
      end
      default: begin
        state_d = S_IDLE;
        pos_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  assign tp      = fire ? (NTP'(1) << pos_q.idx) : '0;
  assign run     = (state_q != S_IDLE);
  assign paused  = (state_q == S_PAUSE);
  assign cyc_end = at_last && stop;

endmodule

// File: tb/tb_pdp1_tp_chain.sv
// Self-checking bench for pdp1_tp_chain.
// Directed vectors for the default instance and a STEP=2/NTP=2 instance, then random stimulus against a pulse-schedule model.
module tb_pdp1_tp_chain;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset_n, start, stop, ihold, ioc;
  logic [9:0] tp;
  logic       run, paused, cyc_end;
  logic [1:0] s_tp;
  logic       s_run, s_paused, s_cyc_end;

  pdp1_tp_chain #(.STEP(25), .NTP(10), .HOLD_TP(7)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .ihold(ihold), .ioc(ioc),
    .tp(tp), .run(run), .paused(paused), .cyc_end(cyc_end)
  );

  pdp1_tp_chain #(.STEP(2), .NTP(2), .HOLD_TP(0)) u_small (
    .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .ihold(ihold), .ioc(ioc),
    .tp(s_tp), .run(s_run), .paused(s_paused), .cyc_end(s_cyc_end)
  );

  // Inputs are {reset_n, start, stop, ihold, ioc}; expected outputs are tp and {run, paused, cyc_end}.
  typedef struct {
    int         sc;
    int         inst;
    int         t;
    logic [4:0] in;
    logic [9:0] etp;
    logic [2:0] o;
  } vec_t;

  vec_t vecs[$];
  vec_t idle_v;
  int   cyc = 0, base = 0, pulses = 0, cur_inst = 0;
  int   errors = 0, checks = 0;
  int   exp_pulses[7] = '{20, 30, 10, 10, 7, 2, 2};

  // Model state: whether a chain is active or parked, and the cycle and index of the next pulse.
  bit m_run[2], m_paused[2];
  int m_next_t[2], m_next_i[2];

  task automatic check(input string name, input int at, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, at, act, exp);
    end
  endtask

  task automatic model_step(input int k);
    int          stp, ntp, hold;
    logic [31:0] act, exp;
    bit          fire;
    stp  = (k == 0) ? 25 : 2;
    ntp  = (k == 0) ? 10 : 2;
    hold = (k == 0) ? 7 : 0;
    act  = (k == 0) ? {19'b0, tp, run, paused, cyc_end} : {27'b0, s_tp, s_run, s_paused, s_cyc_end};
    if (!reset_n) begin
      m_run[k]    = 1'b0;
      m_paused[k] = 1'b0;
      check((k == 0) ? "model_dflt_reset" : "model_small_reset", cyc, act, 32'h0);
    end else begin
      fire   = m_run[k] && !m_paused[k] && (cyc == m_next_t[k]);
      exp    = '0;
      exp[2] = m_run[k];
      exp[1] = m_paused[k];
      if (fire) begin
        exp[3 + m_next_i[k]] = 1'b1;
        exp[0] = (m_next_i[k] == ntp - 1) && stop;
      end
      check((k == 0) ? "model_dflt" : "model_small", cyc, act, exp);
      if (!m_run[k]) begin
        if (start) begin
          m_run[k]    = 1'b1;
          m_next_t[k] = cyc + 1;
          m_next_i[k] = 0;
        end
      end else if (m_paused[k]) begin
        if (ioc) begin
          m_paused[k] = 1'b0;
          m_next_t[k] = cyc + stp - 1;
          m_next_i[k] = hold + 1;
        end
      end else if (fire) begin
        if (m_next_i[k] == ntp - 1 && stop) begin
          m_run[k] = 1'b0;
        end else if (m_next_i[k] == hold && ihold) begin
          m_paused[k] = 1'b1;
        end else begin
          m_next_t[k] = cyc + stp;
          m_next_i[k] = (m_next_i[k] + 1) % ntp;
        end
      end
    end
  endtask

  // Inputs for this cycle are already driven. Check at negedge, then move to the next cycle.
  task automatic run_cycle(input bit tbl, input vec_t e);
    logic [31:0] act;
    @(negedge clk);
    if (tbl) begin
      act = (e.inst == 0) ? {19'b0, tp, run, paused, cyc_end} : {27'b0, s_tp, s_run, s_paused, s_cyc_end};
      check($sformatf("sc%0d_t%0d", e.sc, e.t), cyc - base, act, {19'b0, e.etp, e.o});
    end
    model_step(0);
    model_step(1);
    pulses += (cur_inst == 0) ? $countones(tp) : $countones(s_tp);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    {reset_n, start, stop, ihold, ioc} = 5'b00000;
    run_cycle(1'b0, idle_v);
    run_cycle(1'b0, idle_v);
    reset_n = 1'b1;
    pulses  = 0;
  endtask

  task automatic add(input int sc, input int t, input logic [4:0] in, input logic [9:0] etp, input logic [2:0] o);
    vec_t v;
    v.sc   = sc;
    v.inst = (sc >= 6) ? 1 : 0;
    v.t    = t;
    v.in   = in;
    v.etp  = etp;
    v.o    = o;
    vecs.push_back(v);
  endtask

  initial begin
    int cur_sc;
    idle_v = '{sc: 0, inst: 0, t: 0, in: 5'b0, etp: 10'b0, o: 3'b0};
    {reset_n, start, stop, ihold, ioc} = 5'b00000;

    // sc1: single stopped cycle, then an immediate restart right after cyc_end.
    add(1,   0, 5'b10100, 10'h000, 3'b000);
    add(1,  10, 5'b11100, 10'h000, 3'b000);
    add(1,  11, 5'b10100, 10'h001, 3'b100);
    add(1,  12, 5'b10100, 10'h000, 3'b100);
    add(1,  36, 5'b10100, 10'h002, 3'b100);
    add(1,  61, 5'b10100, 10'h004, 3'b100);
    add(1, 236, 5'b10100, 10'h200, 3'b101);
    add(1, 237, 5'b11100, 10'h000, 3'b000);
    add(1, 238, 5'b10100, 10'h001, 3'b100);
    add(1, 463, 5'b10100, 10'h200, 3'b101);
    add(1, 464, 5'b10100, 10'h000, 3'b000);
    // sc2: free-run for two cycles with ihold edges that must not pause, then stop.
    add(2,   0, 5'b10000, 10'h000, 3'b000);
    add(2,  10, 5'b11000, 10'h000, 3'b000);
    add(2,  11, 5'b10000, 10'h001, 3'b100);
    add(2, 100, 5'b10010, 10'h000, 3'b100);
    add(2, 185, 5'b10000, 10'h000, 3'b100);
    add(2, 186, 5'b10000, 10'h080, 3'b100);
    add(2, 187, 5'b10010, 10'h000, 3'b100);
    add(2, 211, 5'b10010, 10'h100, 3'b100);
    add(2, 236, 5'b10010, 10'h200, 3'b100);
    add(2, 261, 5'b10010, 10'h001, 3'b100);
    add(2, 300, 5'b10000, 10'h000, 3'b100);
    add(2, 436, 5'b10000, 10'h080, 3'b100);
    add(2, 437, 5'b10000, 10'h000, 3'b100);
    add(2, 486, 5'b10000, 10'h200, 3'b100);
    add(2, 511, 5'b10000, 10'h001, 3'b100);
    add(2, 600, 5'b10100, 10'h000, 3'b100);
    add(2, 736, 5'b10100, 10'h200, 3'b101);
    add(2, 737, 5'b10100, 10'h000, 3'b000);
    // sc3: pause at tp[7], resume on ioc at 400.
    add(3,  10, 5'b11100, 10'h000, 3'b000);
    add(3,  11, 5'b10100, 10'h001, 3'b100);
    add(3, 186, 5'b10110, 10'h080, 3'b100);
    add(3, 187, 5'b10100, 10'h000, 3'b110);
    add(3, 400, 5'b10101, 10'h000, 3'b110);
    add(3, 401, 5'b10100, 10'h000, 3'b100);
    add(3, 423, 5'b10100, 10'h000, 3'b100);
    add(3, 424, 5'b10100, 10'h100, 3'b100);
    add(3, 449, 5'b10100, 10'h200, 3'b101);
    add(3, 450, 5'b10100, 10'h000, 3'b000);
    // sc4: a second start and a stray ioc are ignored, and the pause waits for a fresh ioc.
    add(4,  10, 5'b11100, 10'h000, 3'b000);
    add(4,  11, 5'b10100, 10'h001, 3'b100);
    add(4,  50, 5'b11100, 10'h000, 3'b100);
    add(4,  51, 5'b10100, 10'h000, 3'b100);
    add(4,  61, 5'b10100, 10'h004, 3'b100);
    add(4, 100, 5'b10101, 10'h000, 3'b100);
    add(4, 101, 5'b10100, 10'h000, 3'b100);
    add(4, 186, 5'b10110, 10'h080, 3'b100);
    add(4, 187, 5'b10100, 10'h000, 3'b110);
    add(4, 300, 5'b10100, 10'h000, 3'b110);
    add(4, 350, 5'b10101, 10'h000, 3'b110);
    add(4, 351, 5'b10100, 10'h000, 3'b100);
    add(4, 374, 5'b10100, 10'h100, 3'b100);
    add(4, 399, 5'b10100, 10'h200, 3'b101);
    add(4, 400, 5'b10100, 10'h000, 3'b000);
    // sc5: reset mid-chain for 3 clocks, then restart at 130.
    add(5,  10, 5'b11100, 10'h000, 3'b000);
    add(5,  11, 5'b10100, 10'h001, 3'b100);
    add(5, 111, 5'b10100, 10'h010, 3'b100);
    add(5, 120, 5'b00100, 10'h000, 3'b000);
    add(5, 122, 5'b00100, 10'h000, 3'b000);
    add(5, 123, 5'b10100, 10'h000, 3'b000);
    add(5, 124, 5'b10100, 10'h000, 3'b000);
    add(5, 130, 5'b11100, 10'h000, 3'b000);
    add(5, 131, 5'b10100, 10'h001, 3'b100);
    add(5, 156, 5'b10100, 10'h002, 3'b100);
    // sc6/sc7: STEP=2, NTP=2, HOLD_TP=0 instance; plain cycle, then pause with ioc right behind it.
    add(6,   5, 5'b11100, 10'h000, 3'b000);
    add(6,   6, 5'b10100, 10'h001, 3'b100);
    add(6,   7, 5'b10100, 10'h000, 3'b100);
    add(6,   8, 5'b10100, 10'h002, 3'b101);
    add(6,   9, 5'b10100, 10'h000, 3'b000);
    add(7,   5, 5'b11100, 10'h000, 3'b000);
    add(7,   6, 5'b10110, 10'h001, 3'b100);
    add(7,   7, 5'b10101, 10'h000, 3'b110);
    add(7,   8, 5'b10100, 10'h002, 3'b101);
    add(7,   9, 5'b10100, 10'h000, 3'b000);

    cur_sc = 0;
    foreach (vecs[i]) begin
      if (vecs[i].sc != cur_sc) begin
        if (cur_sc != 0) check($sformatf("sc%0d_pulse_count", cur_sc), cyc - base, pulses, exp_pulses[cur_sc-1]);
        do_reset();
        cur_sc   = vecs[i].sc;
        cur_inst = vecs[i].inst;
        base     = cyc;
      end
      while (cyc - base < vecs[i].t) run_cycle(1'b0, vecs[i]);
      {reset_n, start, stop, ihold, ioc} = vecs[i].in;
      run_cycle(1'b1, vecs[i]);
    end
    check($sformatf("sc%0d_pulse_count", cur_sc), cyc - base, pulses, exp_pulses[cur_sc-1]);

    // Random stimulus; both instances are scored every cycle by the model.
    do_reset();
    cur_inst = 0;
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 199) != 0);
      start   = ($urandom_range(0, 19) == 0);
      stop    = ($urandom_range(0, 2) == 0);
      ihold   = ($urandom_range(0, 1) == 1);
      ioc     = ($urandom_range(0, 29) == 0);
      run_cycle(1'b0, idle_v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
